// File: rtl/bist_lfsr_ctrl.sv
`default_nettype none
// ============================================================================
// bist_lfsr_ctrl : Galois-LFSR pattern source + MISR compactor with golden compare.
// Optional macro BIST_SIG_OUT_EN exposes the MISR as `signature`.  Rev 1.0
// ============================================================================
module bist_lfsr_ctrl #(
  parameter int                LFSR_W     = 4,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 4'h3,
  parameter logic [LFSR_W-1:0] SEED       = 4'h1,
  parameter int                MISR_W     = 4,
  parameter logic [MISR_W-1:0] MISR_POLY  = 4'h3,
  parameter int                N_PATTERNS = 15,
  parameter logic [MISR_W-1:0] GOLDEN     = 4'h9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bist_start,
  input  logic [MISR_W-1:0] cut_out,
  output logic [LFSR_W-1:0] cut_in,
  output logic              test_mode,
  output logic              bist_end,
  output logic              pass_nfail
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [MISR_W-1:0] signature
`endif
);

  localparam int                CNT_W    = $clog2(N_PATTERNS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_PATTERNS - 1);

  typedef enum logic [2:0] {IDLE, INIT, RUN, CMP, DONE} state_t;

  state_t             state;
  logic [LFSR_W-1:0]  lfsr;
  logic [MISR_W-1:0]  misr;
  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               trigger;

  // An all-zero seed locks the LFSR at zero, so reject it at elaboration.
  if (SEED == '0) begin : g_seed_chk
    $error("bist_lfsr_ctrl: SEED must be nonzero");
  end

  assign trigger = bist_start & ~start_q;
  assign cut_in  = lfsr;

`ifdef BIST_SIG_OUT_EN
  assign signature = misr;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= '0;
      misr       <= '0;
      cnt        <= '0;
      start_q    <= 1'b0;
      test_mode  <= 1'b0;
      bist_end   <= 1'b0;
      pass_nfail <= 1'b0;
    end else begin
      start_q <= bist_start;
      case (state)
        IDLE, DONE: begin
          if (trigger) state <= INIT;
        end
        INIT: begin
          lfsr       <= SEED;
          misr       <= '0;
          cnt        <= '0;
          test_mode  <= 1'b1;
          bist_end   <= 1'b0;
          pass_nfail <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          misr <= ({misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : '0)) ^ cut_out;
          lfsr <= {lfsr[LFSR_W-2:0], 1'b0} ^ (lfsr[LFSR_W-1] ? LFSR_POLY : '0);
          cnt  <= cnt + 1'b1;
          // cnt still holds the pre-increment index, so this edge absorbs the last pattern
          if (cnt == LAST_CNT) state <= CMP;
        end
        CMP: begin
          pass_nfail <= (misr == GOLDEN);
          bist_end   <= 1'b1;
          test_mode  <= 1'b0;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bist_lfsr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bist_lfsr_ctrl : scoreboard bench for bist_lfsr_ctrl (default parameters).
// Rev 1.0
// ============================================================================
module tb_bist_lfsr_ctrl;

  logic       clock;
  logic       reset;
  logic       bist_start;
  logic [3:0] cut_out;
  logic [3:0] cut_in;
  logic       test_mode;
  logic       bist_end;
  logic       pass_nfail;
`ifdef BIST_SIG_OUT_EN
  logic [3:0] signature;
`endif

  logic [3:0] mask;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic       prev_end = 1'b0;

  typedef struct {
    logic       pass;
    logic [3:0] sig;
    int         edge_n;
  } res_t;

  logic [3:0] pat_q[$];
  res_t       res_q[$];
  int         drop_q[$];

  logic [3:0] pats [0:14] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                              4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

  bist_lfsr_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .bist_start (bist_start),
    .cut_out    (cut_out),
    .cut_in     (cut_in),
    .test_mode  (test_mode),
    .bist_end   (bist_end),
    .pass_nfail (pass_nfail)
`ifdef BIST_SIG_OUT_EN
    ,
    .signature  (signature)
`endif
  );

  assign cut_out = cut_in & mask;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  task automatic unexpected(input string nm, input int act);
    n_chk++;
    $display("FAIL %s: got unexpected event value %0h, expected none (cycle %0d)", nm, act, cyc);
  endtask

  // Monitor: samples on the falling edge and checks against the queues.
  always @(negedge clock) begin
    res_t r;
    int   d;
    if (!reset) begin
      chk("reset_outputs", {cut_in, test_mode, bist_end, pass_nfail}, 0);
`ifdef BIST_SIG_OUT_EN
      chk("reset_signature", signature, 0);
`endif
    end else begin
      if (test_mode) begin
        if (pat_q.size() == 0) unexpected("pattern", cut_in);
        else chk("cut_in", cut_in, pat_q.pop_front());
      end
      if (bist_end && !prev_end) begin
        if (res_q.size() == 0) unexpected("bist_end_rise", cyc);
        else begin
          r = res_q.pop_front();
          chk("end_edge", cyc, r.edge_n);
          chk("pass_nfail", pass_nfail, r.pass);
`ifdef BIST_SIG_OUT_EN
          chk("signature", signature, r.sig);
`endif
        end
      end
      if (!bist_end && prev_end) begin
        if (drop_q.size() == 0) unexpected("bist_end_drop", cyc);
        else begin
          d = drop_q.pop_front();
          chk("drop_edge", cyc, d);
        end
      end
    end
    prev_end <= bist_end;
  end

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  // Queue the whole expected run, then raise bist_start; the next edge is E0.
  task automatic launch(input logic [3:0] m, input logic ep, input logic [3:0] es,
                        input bit from_done, output int c0);
    mask = m;
    c0   = cyc;
    for (int i = 0; i < 15; i++) pat_q.push_back(pats[i]);
    // test_mode stays high through the CMP cycle while the LFSR holds its wrapped value
    pat_q.push_back(pats[0]);
    res_q.push_back('{ep, es, c0 + 18});
    if (from_done) drop_q.push_back(c0 + 2);
    bist_start = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && res_q.size() != 0; i++) tick();
    if (res_q.size() != 0) begin
      n_chk++;
      $display("FAIL run_timeout: %0d results outstanding, expected 0", res_q.size());
      pat_q.delete();
      res_q.delete();
      drop_q.delete();
    end
  endtask

  initial begin
    int c;
    reset      = 1'b0;
    bist_start = 1'b0;
    mask       = 4'hF;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Loopback run from IDLE
    launch(4'hF, 1'b1, 4'h9, 1'b0, c);
    tick(); bist_start = 1'b0;
    wait_done();

    // Retrigger from DONE
    launch(4'hF, 1'b1, 4'h9, 1'b1, c);
    tick(); bist_start = 1'b0;
    wait_done();

    // Bit0 stuck-at-0 response
    launch(4'hE, 1'b0, 4'h4, 1'b1, c);
    tick(); bist_start = 1'b0;
    wait_done();

    // bist_start held for 40 cycles: one run only, bist_end must not drop
    launch(4'hF, 1'b1, 4'h9, 1'b1, c);
    repeat (40) tick();
    bist_start = 1'b0;
    wait_done();
    repeat (5) tick();

    // Second pulse during RUN is ignored
    launch(4'hF, 1'b1, 4'h9, 1'b1, c);
    tick(); bist_start = 1'b0;
    repeat (4) tick();
    bist_start = 1'b1;
    tick(); bist_start = 1'b0;
    wait_done();

    // Reset while pattern 7 is on cut_in
    launch(4'hF, 1'b1, 4'h9, 1'b1, c);
    tick(); bist_start = 1'b0;
    repeat (7) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pat_q.delete();
    res_q.delete();
    drop_q.delete();
    repeat (10) tick();

    // Fresh run after the abort
    launch(4'hF, 1'b1, 4'h9, 1'b0, c);
    tick(); bist_start = 1'b0;
    wait_done();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bist_lfsr_ctrl.md
# bist_lfsr_ctrl

Parametrised self-test controller that supersedes the fixed single-pattern BIST top level. It drives a combinational circuit-under-test (CUT) with pseudo-random patterns from a Galois LFSR and compacts the responses in a MISR. At the end of a run it compares the signature against a golden value and reports `bist_end`/`pass_nfail` to the system. It sits between the system test port and the CUT input/output muxing.

## Interface
- `LFSR_W`, 4: pattern width in bits (≥2).
- `LFSR_POLY`, 4'h3: Galois feedback taps (x^4+x+1).
- `SEED`, 4'h1: LFSR load value; must be nonzero.
- `MISR_W`, 4: response/signature width (≥2).
- `MISR_POLY`, 4'h3: MISR feedback taps.
- `N_PATTERNS`, 15: patterns per run (≥1).
- `GOLDEN`, 4'h9: expected final signature.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `bist_start`  in  1  run request; rising edge triggers a run.
- `cut_out`  in  MISR_W  CUT response, combinational from `cut_in`.
- `cut_in`  out  LFSR_W  pattern to CUT (= LFSR register).
- `test_mode`  out  1  high while patterns are applied (CUT input mux select).
- `bist_end`  out  1  run complete; held until the next run starts or reset.
- `pass_nfail`  out  1  1 = signature matched; valid only while `bist_end`=1.

## Operation
- Start detect: `start_q` registers `bist_start`; trigger = `bist_start & ~start_q`. Holding `bist_start` high gives one run only.
- FSM states: IDLE, INIT, RUN, CMP, DONE.
  - IDLE/DONE + trigger → INIT.
  - INIT → RUN (1 cycle). Loads LFSR←SEED, MISR←0, cnt←0, sets `test_mode`←1, clears `bist_end` and `pass_nfail`.
  - RUN, each cycle:
    - MISR ← ({misr[MISR_W-2:0],0} ^ (misr[MISR_W-1] ? MISR_POLY : 0)) ^ `cut_out`.
    - LFSR ← {lfsr[LFSR_W-2:0],0} ^ (lfsr[LFSR_W-1] ? LFSR_POLY : 0).
    - cnt ← cnt+1.
    - When cnt = N_PATTERNS-1 (the last absorption) → CMP.
  - CMP → DONE: `pass_nfail` ← (MISR == GOLDEN), `bist_end` ← 1, `test_mode` ← 0.
- Triggers during INIT/RUN/CMP are ignored; `start_q` still tracks `bist_start`.
- Counter width is $clog2(N_PATTERNS+1). All arithmetic is modulo register width; no saturation.
- A zero SEED is illegal. Simulation flags it with `$error` at time 0.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `cut_in`=0, `test_mode`=0, `bist_end`=0, `pass_nfail`=0, MISR=0, cnt=0, `start_q`=0. Outputs take these values after that edge.
- Reset mid-run aborts immediately. No partial result is reported, and a fresh rising edge of `bist_start` is required afterwards.
- Latency, counted from edge E0 where the trigger is sampled:
  - INIT during E0→E1.
  - `test_mode`=1 from E1.
  - Patterns 1..N_PATTERNS are presented during E1→E2 … EN→EN+1.
  - CMP during EN+1→EN+2.
  - `bist_end`/`pass_nfail` are valid from EN+2.
- A retrigger in DONE clears `bist_end` at the next edge (INIT).
- `cut_out` must settle within one clock period of `cut_in`.

## Configuration
- `BIST_SIG_OUT_EN` defined:
  - Adds output `signature` [MISR_W-1:0], driven directly by the MISR register.
  - Resets to 0; valid as the final signature while `bist_end`=1.
- Not defined: the port and all related logic are absent. Behaviour is otherwise identical.

## Test plan
- Default parameters, `cut_out`=`cut_in` loopback, pulse `bist_start`:
  - `cut_in` sequence 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9.
  - `bist_end`=1 at E17, `pass_nfail`=1.
  - `signature`=4'h9 when `BIST_SIG_OUT_EN` is defined.
- Same setup with `cut_out`=`cut_in` & 4'hE (bit0 stuck-at-0) → `bist_end`=1 at E17, `pass_nfail`=0, `signature`=4'h4.
- `bist_start` held high for 40 cycles → exactly one run. `bist_end` stays 1 from E17 with no second INIT.
- `reset`=0 for one cycle at pattern 7, then released → all outputs 0. State stays IDLE until the next rising edge of `bist_start`; the following loopback run passes.
- Passing run, then second pulse in DONE → `bist_end` drops at the next edge and rises again 17 edges after the trigger, `pass_nfail`=1.
- `bist_start` pulsed again during RUN → ignored; completion edge unchanged at E17.
